ldpc_parity_streamer: RTL and testbench

//  Drains the encoder's parity buffer after each codeword and presents the parity blocks as a

---
 rtl/ldpc_parity_streamer_pkg.sv | 22 ++
 rtl/ldpc_parity_streamer_if.sv | 12 +
 rtl/ldpc_parity_streamer_fifo.sv | 42 ++++
 rtl/ldpc_parity_streamer.sv | 103 ++++++++++
 tb/tb_ldpc_parity_streamer.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ldpc_parity_streamer_pkg.sv
// Shared types and constants for the LDPC parity streamer: state encoding, FIFO entry layout, zc mask helper.
package ldpc_parity_streamer_pkg;
  localparam int MAX_ZC       = 384;
  localparam int ADDR_W       = 9;
  localparam int ZC_W         = 9;
  localparam int MAX_PAR_BLKS = 46;
  localparam int PAR_IDX_W    = 6;
  localparam int FIFO_DEPTH   = 2;

  typedef enum logic [1:0] {PS_IDLE, PS_READ, PS_DRAIN} par_stream_state_t;

  typedef struct packed {
    logic                 last;
    logic [PAR_IDX_W-1:0] index;
    logic [MAX_ZC-1:0]    data;
  } par_entry_t;

  // Ones below zc; a shift of zc >= MAX_ZC leaves the whole block unmasked.
  function automatic logic [MAX_ZC-1:0] zc_mask(input logic [ZC_W-1:0] zc);
    return ~({MAX_ZC{1'b1}} << zc);
  endfunction
endpackage

// File: rtl/ldpc_parity_streamer_if.sv
// Parity block stream toward rate matching: data/index/last with valid/ready.
interface ldpc_parity_streamer_if;
  import ldpc_parity_streamer_pkg::*;
  logic [MAX_ZC-1:0]    data;
  logic [PAR_IDX_W-1:0] index;
  logic                 last;
  logic                 valid;
  logic                 ready;

  modport master (output data, index, last, valid, input ready);
  modport slave  (input data, index, last, valid, output ready);
endinterface

// File: rtl/ldpc_parity_streamer_fifo.sv
// Two-entry skid FIFO holding tagged parity blocks; push and pop may coincide.
module par_skid_fifo
  import ldpc_parity_streamer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  par_entry_t din,
  output par_entry_t head,
  output logic [1:0] count
);
  par_entry_t mem [FIFO_DEPTH];
  logic       wr_ptr, rd_ptr;

  assign head = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // The upstream credit rule is what keeps this from ever firing.
  a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && !pop && count == 2'd2));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(pop && count == 2'd0));
endmodule

// File: rtl/ldpc_parity_streamer.sv
// Drains the encoder parity buffer after each codeword and streams zc-masked, index/last tagged blocks.
module ldpc_parity_streamer
  import ldpc_parity_streamer_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cw_vector_valid,
  input  logic [ZC_W-1:0]       zc,
  input  logic [PAR_IDX_W-1:0]  n_par_blks,
  input  logic [MAX_ZC-1:0]     parity_out,
  output logic [ADDR_W-1:0]     parity_out_address,
  output logic                  parity_out_rd_en,
  ldpc_parity_streamer_if.master blk,
  output logic                  busy,
  output logic                  start_err
);
  par_stream_state_t    state;
  logic [PAR_IDX_W-1:0] n_lat, rd_cnt, fl_idx;
  logic                 fl_last, inflight;
  logic [MAX_ZC-1:0]    mask;
  logic [1:0]           fifo_count;
  par_entry_t           in_e, head_e, out_e;
  logic                 push, pop, hs, credit, start_ok;

  assign credit             = (fifo_count + {1'b0, inflight}) < 2'd2;
  assign parity_out_rd_en   = (state == PS_READ) && credit;
  assign parity_out_address = ADDR_W'(rd_cnt);
  assign start_ok           = (n_par_blks != '0) && (n_par_blks <= PAR_IDX_W'(MAX_PAR_BLKS));

  assign in_e = '{last: fl_last, index: fl_idx, data: parity_out & mask};

  // Returning read data is presented directly when the FIFO is empty, so an
  // accepting sink sees one block per cycle; otherwise it lands in the FIFO.
  assign out_e = (fifo_count != 2'd0) ? head_e : (inflight ? in_e : '0);
  assign hs    = blk.valid && blk.ready;
  assign pop   = hs && (fifo_count != 2'd0);
  assign push  = inflight && !((fifo_count == 2'd0) && blk.ready);

  assign blk.valid = (fifo_count != 2'd0) || inflight;
  assign blk.data  = out_e.data;
  assign blk.index = out_e.index;
  assign blk.last  = out_e.last;

  par_skid_fifo u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (push),
    .pop   (pop),
    .din   (in_e),
    .head  (head_e),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= PS_IDLE;
      n_lat     <= '0;
      rd_cnt    <= '0;
      fl_idx    <= '0;
      fl_last   <= 1'b0;
      inflight  <= 1'b0;
      mask      <= '0;
      busy      <= 1'b0;
      start_err <= 1'b0;
    end else begin
      start_err <= 1'b0;
      inflight  <= parity_out_rd_en;
      if (parity_out_rd_en) begin
        fl_idx  <= rd_cnt;
        fl_last <= (rd_cnt == n_lat - PAR_IDX_W'(1));
        rd_cnt  <= rd_cnt + PAR_IDX_W'(1);
      end
      case (state)
        PS_IDLE: begin
          if (cw_vector_valid) begin
            if (start_ok) begin
              n_lat  <= n_par_blks;
              mask   <= zc_mask(zc);
              rd_cnt <= '0;
              busy   <= 1'b1;
              state  <= PS_READ;
            end else begin
              start_err <= 1'b1;
            end
          end
        end
        PS_READ: begin
          if (cw_vector_valid) start_err <= 1'b1;
          if (parity_out_rd_en && (rd_cnt == n_lat - PAR_IDX_W'(1))) state <= PS_DRAIN;
        end
        PS_DRAIN: begin
          // A start coinciding with the final handshake still sees busy and is rejected.
          if (cw_vector_valid) start_err <= 1'b1;
          if (hs && out_e.last) begin
            state <= PS_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= PS_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ldpc_parity_streamer.sv
// Scoreboard bench for ldpc_parity_streamer: directed codewords, monitor pops expected blocks on handshake.
module tb_ldpc_parity_streamer;
  import ldpc_parity_streamer_pkg::*;

  typedef struct {
    logic [MAX_ZC-1:0]    data;
    logic [PAR_IDX_W-1:0] index;
    logic                 last;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 cw_vector_valid;
  logic [ZC_W-1:0]      zc;
  logic [PAR_IDX_W-1:0] n_par_blks;
  logic [MAX_ZC-1:0]    parity_out;
  logic [ADDR_W-1:0]    parity_out_address;
  logic                 parity_out_rd_en;
  logic                 busy, start_err;

  ldpc_parity_streamer_if bif();

  ldpc_parity_streamer dut (
    .clk                (clk),
    .reset              (reset),
    .cw_vector_valid    (cw_vector_valid),
    .zc                 (zc),
    .n_par_blks         (n_par_blks),
    .parity_out         (parity_out),
    .parity_out_address (parity_out_address),
    .parity_out_rd_en   (parity_out_rd_en),
    .blk                (bif.master),
    .busy               (busy),
    .start_err          (start_err)
  );

  always #5 clk = ~clk;

  logic [MAX_ZC-1:0] mem [64];
  exp_t              sb [$];
  int                n_cmp = 0, n_bad = 0;
  int                hs_total = 0;
  int                cyc = 0;
  bit                consec = 1'b0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Encoder parity buffer model: registered read, data one cycle after rd_en.
  initial begin
    parity_out = '0;
    forever begin
      @(posedge clk);
      if (parity_out_rd_en) parity_out <= mem[parity_out_address[5:0]];
    end
  end

  // Monitor: address/credit checks on reads, scoreboard pops on handshake, stall stability.
  initial begin
    int                   issued, accepted, exp_addr, last_rd_cyc;
    bit                   stall, prev_busy;
    logic [MAX_ZC-1:0]    p_data;
    logic [PAR_IDX_W-1:0] p_idx;
    logic                 p_last;
    exp_t                 e;
    issued = 0; accepted = 0; exp_addr = 0; last_rd_cyc = 0;
    stall = 1'b0; prev_busy = 1'b0;
    p_data = '0; p_idx = '0; p_last = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        sb.delete();
        issued = 0; accepted = 0; exp_addr = 0;
        stall = 1'b0; prev_busy = 1'b0;
      end else begin
        if (busy && !prev_busy) begin
          exp_addr = 0; issued = 0; accepted = 0;
        end
        if (stall) begin
          check("stall_valid", 512'(bif.valid), 512'(1));
          check("stall_data",  512'(bif.data),  512'(p_data));
          check("stall_index", 512'(bif.index), 512'(p_idx));
          check("stall_last",  512'(bif.last),  512'(p_last));
        end
        if (parity_out_rd_en) begin
          check("rd_credit", 512'(issued - accepted < 2), 512'(1));
          check("rd_addr", 512'(parity_out_address), 512'(exp_addr));
          if (consec && exp_addr != 0) check("rd_back_to_back", 512'(cyc), 512'(last_rd_cyc + 1));
          last_rd_cyc = cyc;
          exp_addr++;
          issued++;
        end
        if (bif.valid && bif.ready) begin
          if (sb.size() == 0) begin
            check("unexpected_blk", 512'(bif.index), 512'(63));
          end else begin
            e = sb.pop_front();
            check("blk_data",  512'(bif.data),  512'(e.data));
            check("blk_index", 512'(bif.index), 512'(e.index));
            check("blk_last",  512'(bif.last),  512'(e.last));
          end
          accepted++;
          hs_total++;
        end
        stall     = bif.valid && !bif.ready;
        p_data    = bif.data;
        p_idx     = bif.index;
        p_last    = bif.last;
        prev_busy = busy;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [MAX_ZC-1:0] tb_mask(input int z);
    logic [MAX_ZC-1:0] m;
    for (int b = 0; b < MAX_ZC; b++) m[b] = (b < z);
    return m;
  endfunction

  task automatic fill(input int tag);
    logic [31:0] w;
    for (int i = 0; i < 64; i++) begin
      w = {8'(tag), 8'(i), 16'h5a3c ^ 16'(i * 7)};
      mem[i] = {12{w}};
    end
  endtask

  // Pulses a start; expectations are queued only when the start should be accepted.
  task automatic start_cw(input int z, input int n, input bit expect_ok);
    logic [MAX_ZC-1:0] m;
    exp_t e;
    m = tb_mask(z);
    if (expect_ok) begin
      for (int i = 0; i < n; i++) begin
        e.data  = mem[i] & m;
        e.index = PAR_IDX_W'(i);
        e.last  = (i == n - 1);
        sb.push_back(e);
      end
    end
    zc = ZC_W'(z);
    n_par_blks = PAR_IDX_W'(n);
    cw_vector_valid = 1'b1;
    tick();
    cw_vector_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while ((busy || sb.size() != 0) && k < 1000) begin
      tick();
      k++;
    end
    check({name, "_done"}, 512'(busy || sb.size() != 0), 512'(0));
  endtask

  task automatic wait_hs(input int target);
    int k;
    k = 0;
    while (hs_total < target && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("wait_hs_timeout", 512'(hs_total >= target), 512'(1));
  endtask

  initial begin
    logic [MAX_ZC-1:0] c2;
    logic [3:0]        pat;
    exp_t              e;
    int                k;
    reset = 1'b1; cw_vector_valid = 1'b0; zc = '0; n_par_blks = '0; bif.ready = 1'b0;
    fill(1);
    repeat (3) tick();
    @(negedge clk);
    check("rst_rd_en", 512'(parity_out_rd_en), 512'(0));
    check("rst_valid", 512'(bif.valid), 512'(0));
    check("rst_busy",  512'(busy), 512'(0));
    check("rst_err",   512'(start_err), 512'(0));
    check("rst_data",  512'(bif.data), 512'(0));
    tick();
    reset = 1'b0;
    tick();

    // 1: full BG1 codeword, unmasked, streaming back to back.
    bif.ready = 1'b1;
    consec = 1'b1;
    start_cw(384, 46, 1'b1);
    k = 0;
    @(negedge clk);
    while (!bif.valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    for (int i = 0; i < 46; i++) begin
      check("t1_no_bubble", 512'(bif.valid), 512'(1));
      if (i < 45) @(negedge clk);
    end
    @(negedge clk);
    check("t1_busy_fall", 512'(busy), 512'(0));
    consec = 1'b0;
    wait_done("t1");

    // 2: zc=52 masking with an all-ones buffer.
    for (int i = 0; i < 64; i++) mem[i] = '1;
    c2 = {332'b0, 52'hF_FFFF_FFFF_FFFF};
    for (int i = 0; i < 4; i++) begin
      e.data = c2; e.index = PAR_IDX_W'(i); e.last = (i == 3);
      sb.push_back(e);
    end
    start_cw(52, 4, 1'b0);
    wait_done("t2");

    // 3: backpressure pattern 1,0,0,1.
    fill(3);
    pat = 4'b1001;
    start_cw(100, 10, 1'b1);
    k = 0;
    while ((busy || sb.size() != 0) && k < 400) begin
      bif.ready = pat[k % 4];
      tick();
      k++;
    end
    check("t3_done", 512'(busy || sb.size() != 0), 512'(0));
    bif.ready = 1'b1;

    // 4: single block codeword.
    fill(4);
    start_cw(384, 1, 1'b1);
    @(negedge clk);
    check("t4_rd_en", 512'(parity_out_rd_en), 512'(1));
    @(negedge clk);
    check("t4_valid", 512'(bif.valid), 512'(1));
    check("t4_no_rd", 512'(parity_out_rd_en), 512'(0));
    @(negedge clk);
    check("t4_busy_fall", 512'(busy), 512'(0));
    wait_done("t4");

    // 5: start while busy, then a zero-length start in IDLE.
    fill(5);
    k = hs_total;
    start_cw(200, 20, 1'b1);
    wait_hs(k + 5);
    @(posedge clk); #1;
    start_cw(200, 3, 1'b0);
    @(negedge clk);
    check("t5_err_busy", 512'(start_err), 512'(1));
    check("t5_still_busy", 512'(busy), 512'(1));
    @(negedge clk);
    check("t5_err_pulse", 512'(start_err), 512'(0));
    wait_done("t5a");
    start_cw(200, 0, 1'b0);
    @(negedge clk);
    check("t5_err_zero", 512'(start_err), 512'(1));
    check("t5_idle_busy", 512'(busy), 512'(0));
    @(negedge clk);
    check("t5_idle_rd", 512'(parity_out_rd_en), 512'(0));
    check("t5_idle_busy2", 512'(busy), 512'(0));

    // 6: reset mid-codeword with the sink stalled, then a clean restart.
    fill(6);
    k = hs_total;
    start_cw(384, 30, 1'b1);
    wait_hs(k + 7);
    bif.ready = 1'b0;
    repeat (4) tick();
    #2 reset = 1'b1;
    #1;
    check("t6_rst_rd_en", 512'(parity_out_rd_en), 512'(0));
    check("t6_rst_valid", 512'(bif.valid), 512'(0));
    check("t6_rst_busy",  512'(busy), 512'(0));
    @(negedge clk);
    tick();
    reset = 1'b0;
    tick();
    bif.ready = 1'b1;
    fill(7);
    start_cw(300, 3, 1'b1);
    wait_done("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
